// File: rtl/periplex_pkg.sv
// Shared definitions for the periplex command parser.
// Holds the fixed frame marker and response bytes, the command-byte
// field positions, and the parser state encoding.
package periplex_pkg;

  localparam int DATA_W = 8;
  localparam int RW_BIT = 7;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h5A;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CMD       = 4'd1,
    S_DATA      = 4'd2,
    S_CSUM      = 4'd3,
    S_EXEC      = 4'd4,
    S_RD_WAIT   = 4'd5,
    S_TX_ACK    = 4'd6,
    S_WAIT_ACK  = 4'd7,
    S_TX_DATA   = 4'd8,
    S_WAIT_DATA = 4'd9
  } state_t;

endpackage

// File: rtl/periplex_cmd_parser_if.sv
// Bundle of the UART byte stream and register-file access signals around
// the command parser.
//   master : UART RX/TX and register file side (drives rx_*, tx_done, reg_rdata)
//   slave  : the parser (drives tx_*, reg_* strobes/address/data, hold, frame_err)
interface periplex_cmd_parser_if #(
  parameter int ADDR_W = 7
);
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_done;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;
  logic              hold;
  logic              frame_err;

  modport master (
    output rx_dv, rx_byte, tx_done, reg_rdata,
    input  tx_dv, tx_byte, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, hold, frame_err
  );

  modport slave (
    input  rx_dv, rx_byte, tx_done, reg_rdata,
    output tx_dv, tx_byte, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, hold, frame_err
  );
endinterface

// File: rtl/periplex_timeout_ctr.sv
// Inter-byte timeout counter.
//   clk1, rst_n : clock, async active-low reset
//   clr         : synchronous clear (takes priority over counting)
//   en          : count while high
//   expire      : high while enabled and the count has reached TIMEOUT_CYCLES-1
module periplex_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/periplex_cmd_parser.sv
// Command front-end between the UART and the peripheral register file.
// Parses SYNC / CMD{rw,addr} / DATA frames, issues one-cycle register
// write or read strobes, and answers with an ACK byte (plus the read data
// for reads). hold is high whenever a frame is being handled.
//   clk1, rst_n : clock, async active-low reset
//   bus         : periplex_cmd_parser_if.slave (UART bytes, register access,
//                 hold, frame_err)
// Build option PERIPLEX_CMD_CHECKSUM_EN: frames carry a trailing XOR
// checksum byte; a mismatch pulses frame_err and answers NAK without
// touching the register file.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | hunting for SYNC, other bytes dropped
// CMD       | waiting for command byte (rw, addr)
// DATA      | waiting for write data byte
// CSUM      | waiting for checksum byte (checksum build only)
// EXEC      | one-cycle register write or read strobe
// RD_WAIT   | capturing read data
// TX_ACK    | sending ACK (or NAK)
// WAIT_ACK  | waiting for UART TX to finish ACK/NAK
// TX_DATA   | sending read data
// WAIT_DATA | waiting for UART TX to finish read data
module periplex_cmd_parser
  import periplex_pkg::*;
#(
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  periplex_cmd_parser_if.slave  bus
);

`ifdef PERIPLEX_CMD_CHECKSUM_EN
  localparam state_t FRAME_END = S_CSUM;
`else
  localparam state_t FRAME_END = S_EXEC;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
`ifdef PERIPLEX_CMD_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                nak_q, nak_d;
`endif

  logic to_en, to_clr, to_expire;

  // Counter only runs while a frame is partially received; any received
  // byte or leaving those states restarts it from zero.
  assign to_en  = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign to_clr = bus.rx_dv || !to_en;

  periplex_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .clr    (to_clr),
    .en     (to_en),
    .expire (to_expire)
  );

  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.hold      = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rw_d          = rw_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
`ifdef PERIPLEX_CMD_CHECKSUM_EN
    csum_d        = csum_q;
    nak_d         = nak_q;
`endif
    bus.tx_dv     = 1'b0;
    bus.tx_byte   = 8'h00;
    bus.reg_wr_en = 1'b0;
    bus.reg_rd_en = 1'b0;
    bus.frame_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_dv && (bus.rx_byte == SYNC_BYTE)) begin
          state_d = S_CMD;
`ifdef PERIPLEX_CMD_CHECKSUM_EN
          csum_d  = SYNC_BYTE;
          nak_d   = 1'b0;
`endif
        end
      end

      S_CMD: begin
        // A byte arriving on the expiry cycle still counts as in time.
        if (bus.rx_dv) begin
          addr_d  = bus.rx_byte[ADDR_W-1:0];
          rw_d    = bus.rx_byte[RW_BIT];
          state_d = bus.rx_byte[RW_BIT] ? FRAME_END : S_DATA;
`ifdef PERIPLEX_CMD_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_byte;
`endif
        end else if (to_expire) begin
          bus.frame_err = 1'b1;
          state_d       = S_IDLE;
        end
      end

      S_DATA: begin
        if (bus.rx_dv) begin
          wdata_d = bus.rx_byte;
          state_d = FRAME_END;
`ifdef PERIPLEX_CMD_CHECKSUM_EN
          csum_d  = csum_q ^ bus.rx_byte;
`endif
        end else if (to_expire) begin
          bus.frame_err = 1'b1;
          state_d       = S_IDLE;
        end
      end

`ifdef PERIPLEX_CMD_CHECKSUM_EN
      S_CSUM: begin
        if (bus.rx_dv) begin
          if (bus.rx_byte == csum_q) begin
            state_d = S_EXEC;
          end else begin
            // Bad frame: skip the register access and go straight to NAK.
            bus.frame_err = 1'b1;
            nak_d         = 1'b1;
            state_d       = S_TX_ACK;
          end
        end else if (to_expire) begin
          bus.frame_err = 1'b1;
          state_d       = S_IDLE;
        end
      end
`endif

      S_EXEC: begin
        if (rw_q) begin
          bus.reg_rd_en = 1'b1;
          state_d       = S_RD_WAIT;
        end else begin
          bus.reg_wr_en = 1'b1;
          state_d       = S_TX_ACK;
        end
      end

      S_RD_WAIT: begin
        rdata_d = bus.reg_rdata;
        state_d = S_TX_ACK;
      end

      S_TX_ACK: begin
        bus.tx_dv   = 1'b1;
`ifdef PERIPLEX_CMD_CHECKSUM_EN
        bus.tx_byte = nak_q ? NAK_BYTE : ACK_BYTE;
`else
        bus.tx_byte = ACK_BYTE;
`endif
        state_d     = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (bus.tx_done) begin
`ifdef PERIPLEX_CMD_CHECKSUM_EN
          state_d = (rw_q && !nak_q) ? S_TX_DATA : S_IDLE;
`else
          state_d = rw_q ? S_TX_DATA : S_IDLE;
`endif
        end
      end

      S_TX_DATA: begin
        bus.tx_dv   = 1'b1;
        bus.tx_byte = rdata_q;
        state_d     = S_WAIT_DATA;
      end

      S_WAIT_DATA: begin
        if (bus.tx_done) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef PERIPLEX_CMD_CHECKSUM_EN
      csum_q  <= '0;
      nak_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef PERIPLEX_CMD_CHECKSUM_EN
      csum_q  <= csum_d;
      nak_q   <= nak_d;
`endif
    end
  end

endmodule
